// File: rtl/march_seq.sv
// March C- sequencer for a memory BIST datapath.
// Issues one memory operation per clock (write or read/compare), walks the six
// March C- elements in order, captures the first failing address/element and
// reports completion. Every output is driven straight from a flop.
module march_seq #(
    parameter int Adr_size    = 4,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                error,
    output logic [Adr_size-1:0] adr,
    output logic                wr_en,
    output logic                read_en,
    output logic                data_bit,
    output logic                busy,
    output logic                done,
    output logic                status,
    output logic [Adr_size-1:0] fail_adr,
    output logic [2:0]          fail_elem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [Adr_size-1:0] ADR_ONE = Adr_size'(1);
    localparam logic [Adr_size-1:0] ADR_MAX = '1;
    localparam logic [2:0]          ELEM_LAST = 3'd5;

    state_t              state, state_n;
    logic [2:0]          elem, elem_n;
    logic                phase, phase_n;
    logic [Adr_size-1:0] adr_n;
    logic [Adr_size-1:0] last_adr;
    logic                wr_n, rd_n, data_n, busy_n, done_n, status_n;
    logic [Adr_size-1:0] fail_adr_n;
    logic [2:0]          fail_elem_n;

    // Elements 1..4 are read-then-write at each address; 0 and 5 are single-op.
    function automatic logic two_op(input logic [2:0] e);
        return (e != 3'd0) && (e != ELEM_LAST);
    endfunction

    // Elements 3 and 4 walk the address space from the top down.
    function automatic logic is_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic op_is_write(input logic [2:0] e, input logic p);
        return (e == 3'd0) || (two_op(e) && p);
    endfunction

    // Background bit: E2/E4 expect ones on the read and write zeros back,
    // E1/E3 expect zeros and write ones, E0 writes zeros, E5 reads zeros.
    function automatic logic op_data(input logic [2:0] e, input logic p);
        logic read_val;
        read_val = (e == 3'd2) || (e == 3'd4);
        if (!two_op(e)) return 1'b0;
        return p ? ~read_val : read_val;
    endfunction

    // Next-state, address stepping, error capture and next registered outputs.
    always_comb begin
        state_n     = state;
        elem_n      = elem;
        phase_n     = phase;
        adr_n       = adr;
        status_n    = status;
        fail_adr_n  = fail_adr;
        fail_elem_n = fail_elem;
        last_adr    = is_down(elem) ? '0 : ADR_MAX;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n     = RUN;
                    elem_n      = 3'd0;
                    phase_n     = 1'b0;
                    adr_n       = '0;
                    status_n    = 1'b0;
                    fail_adr_n  = '0;
                    fail_elem_n = 3'd0;
                end
            end
            RUN: begin
                if (read_en && error && !status) begin
                    status_n    = 1'b1;
                    fail_adr_n  = adr;
                    fail_elem_n = elem;
                end
                if (STOP_ON_ERR && read_en && error) begin
                    state_n = DONE;
                    elem_n  = 3'd0;
                    phase_n = 1'b0;
                    adr_n   = '0;
                end else if (two_op(elem) && !phase) begin
                    phase_n = 1'b1;
                end else begin
                    phase_n = 1'b0;
                    if (adr == last_adr) begin
                        if (elem == ELEM_LAST) begin
                            state_n = DONE;
                            elem_n  = 3'd0;
                            adr_n   = '0;
                        end else begin
                            elem_n = elem + 3'd1;
                            adr_n  = is_down(elem_n) ? ADR_MAX : '0;
                        end
                    end else begin
                        adr_n = is_down(elem) ? adr - ADR_ONE : adr + ADR_ONE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == RUN);
        done_n = (state_n == DONE);
        wr_n   = busy_n && op_is_write(elem_n, phase_n);
        rd_n   = busy_n && !op_is_write(elem_n, phase_n);
        data_n = busy_n && op_data(elem_n, phase_n);
    end

    // State register and registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            elem      <= 3'd0;
            phase     <= 1'b0;
            adr       <= '0;
            wr_en     <= 1'b0;
            read_en   <= 1'b0;
            data_bit  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            status    <= 1'b0;
            fail_adr  <= '0;
            fail_elem <= 3'd0;
        end else begin
            state     <= state_n;
            elem      <= elem_n;
            phase     <= phase_n;
            adr       <= adr_n;
            wr_en     <= wr_n;
            read_en   <= rd_n;
            data_bit  <= data_n;
            busy      <= busy_n;
            done      <= done_n;
            status    <= status_n;
            fail_adr  <= fail_adr_n;
            fail_elem <= fail_elem_n;
        end
    end

endmodule

// File: tb/tb_march_seq.sv
// Directed testbench for march_seq: one run-to-completion instance and one
// abort-on-error instance, checked against a March C- op model.
module tb_march_seq;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, error = 1'b0;
    logic          start_a = 1'b0, error_a = 1'b0;

    logic [AW-1:0] adr, fail_adr, adr_a, fail_adr_a;
    logic          wr_en, read_en, data_bit, busy, done, status;
    logic          wr_en_a, read_en_a, data_bit_a, busy_a, done_a, status_a;
    logic [2:0]    fail_elem, fail_elem_a;

    int checks = 0;
    int errors = 0;
    int wr_cnt, rd_cnt, both_cnt;

    march_seq #(.Adr_size(AW), .STOP_ON_ERR(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .error(error),
        .adr(adr), .wr_en(wr_en), .read_en(read_en), .data_bit(data_bit),
        .busy(busy), .done(done), .status(status),
        .fail_adr(fail_adr), .fail_elem(fail_elem)
    );

    march_seq #(.Adr_size(AW), .STOP_ON_ERR(1'b1)) dut_abort (
        .clk(clk), .rst(rst), .start(start_a), .error(error_a),
        .adr(adr_a), .wr_en(wr_en_a), .read_en(read_en_a), .data_bit(data_bit_a),
        .busy(busy_a), .done(done_a), .status(status_a),
        .fail_adr(fail_adr_a), .fail_elem(fail_elem_a)
    );

    always #5 clk = ~clk;

    // Packed view: {busy, done, wr_en, read_en, data_bit, adr[3:0]}
    function automatic logic [8:0] obs(input bit sel);
        if (sel) return {busy_a, done_a, wr_en_a, read_en_a, data_bit_a, adr_a};
        return {busy, done, wr_en, read_en, data_bit, adr};
    endfunction

    // Packed view: {status, fail_elem[2:0], fail_adr[3:0]}
    function automatic logic [7:0] stat(input bit sel);
        if (sel) return {status_a, fail_elem_a, fail_adr_a};
        return {status, fail_elem, fail_adr};
    endfunction

    // Expected op number i (0..159) of a March C- run over 16 words.
    function automatic logic [8:0] exp_op(input int i);
        int  e, j, a;
        logic w, d, rv;
        if (i < 16) begin
            w = 1'b1; d = 1'b0; a = i;
        end else if (i < 144) begin
            e  = (i - 16) / 32 + 1;
            j  = (i - 16) % 32;
            a  = (e <= 2) ? (j / 2) : (15 - j / 2);
            w  = (j % 2) == 1;
            rv = (e == 2) || (e == 4);
            d  = w ? ~rv : rv;
        end else begin
            w = 1'b0; d = 1'b0; a = i - 144;
        end
        return {1'b1, 1'b0, w, ~w, d, a[3:0]};
    endfunction

    task automatic apply_stimulus(input bit sel, input logic st, input logic er);
        if (sel) begin
            start_a = st; error_a = er;
        end else begin
            start = st; error = er;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Starts a run and checks n_ops consecutive op cycles against the model.
    // err_a/err_b are op indices where error is raised; noise raises error on
    // every write cycle; mid_start pulses start again at op 50.
    task automatic run_sequence(input bit sel, input int n_ops, input int err_a,
                                input int err_b, input bit noise, input bit mid_start);
        logic [8:0] e_op, o_op;
        logic       er;
        wr_cnt = 0; rd_cnt = 0; both_cnt = 0;
        @(negedge clk);
        apply_stimulus(sel, 1'b1, 1'b0);
        for (int i = 0; i < n_ops; i++) begin
            @(negedge clk);
            e_op = exp_op(i);
            o_op = obs(sel);
            check_output($sformatf("op%0d", i), {23'd0, o_op}, {23'd0, e_op});
            if (i == 0)
                check_output("start_clears", {24'd0, stat(sel)}, 32'd0);
            if (o_op[6]) wr_cnt++;
            if (o_op[5]) rd_cnt++;
            if (o_op[6] && o_op[5]) both_cnt++;
            er = (i == err_a) || (i == err_b) || (noise && e_op[6]);
            apply_stimulus(sel, mid_start && (i == 50), er);
        end
    endtask

    initial begin
        $display("[TB] march_seq directed test");

        // Reset state
        repeat (3) @(negedge clk);
        check_output("rst_obs", {23'd0, obs(0)}, 32'd0);
        check_output("rst_stat", {24'd0, stat(0)}, 32'd0);
        check_output("rst_obs_abort", {23'd0, obs(1)}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_output("idle_hold", {23'd0, obs(0)}, 32'd0);

        // Clean run with error toggled on write cycles and a mid-run start
        run_sequence(0, 160, -1, -1, 1'b1, 1'b1);
        @(negedge clk);
        apply_stimulus(0, 1'b0, 1'b0);
        check_output("clean_done", {23'd0, obs(0)}, 32'h080);
        check_output("clean_stat", {24'd0, stat(0)}, 32'd0);
        check_output("clean_wr_cnt", wr_cnt, 32'd80);
        check_output("clean_rd_cnt", rd_cnt, 32'd80);
        check_output("clean_both", both_cnt, 32'd0);
        @(negedge clk);
        check_output("done_hold", {23'd0, obs(0)}, 32'h080);

        // Single fault: E2 read @5 then E4 read @9, run continues
        run_sequence(0, 160, 58, 124, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(0, 1'b0, 1'b0);
        check_output("fault_done", {23'd0, obs(0)}, 32'h080);
        check_output("fault_stat", {24'd0, stat(0)}, {24'd0, 1'b1, 3'd2, 4'd5});
        repeat (2) @(negedge clk);
        check_output("fault_stat_hold", {24'd0, stat(0)}, {24'd0, 1'b1, 3'd2, 4'd5});

        // Restart from DONE after a failed run
        run_sequence(0, 160, -1, -1, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(0, 1'b0, 1'b0);
        check_output("restart_done", {23'd0, obs(0)}, 32'h080);
        check_output("restart_stat", {24'd0, stat(0)}, 32'd0);

        // Reset during E1 (after an error at E1 read @1)
        run_sequence(0, 21, 18, -1, 1'b0, 1'b0);
        check_output("e1_fault_stat", {24'd0, stat(0)}, {24'd0, 1'b1, 3'd1, 4'd1});
        rst = 1'b1;
        apply_stimulus(0, 1'b0, 1'b0);
        @(negedge clk);
        check_output("midrun_rst_obs", {23'd0, obs(0)}, 32'd0);
        check_output("midrun_rst_stat", {24'd0, stat(0)}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_output("post_rst_idle", {23'd0, obs(0)}, 32'd0);
        run_sequence(0, 160, -1, -1, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(0, 1'b0, 1'b0);
        check_output("post_rst_done", {23'd0, obs(0)}, 32'h080);

        // Abort instance: error on E3 read @12 stops the run
        run_sequence(1, 87, 86, -1, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(1, 1'b0, 1'b0);
        check_output("abort_done", {23'd0, obs(1)}, 32'h080);
        check_output("abort_stat", {24'd0, stat(1)}, {24'd0, 1'b1, 3'd3, 4'd12});
        repeat (3) @(negedge clk);
        check_output("abort_hold", {23'd0, obs(1)}, 32'h080);
        check_output("abort_stat_hold", {24'd0, stat(1)}, {24'd0, 1'b1, 3'd3, 4'd12});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/march_seq.md
Name: march_seq

Overview:
- Sequences the BIST datapath (memory, data generator, comparator) through the March C- algorithm.
- Issues one memory operation per clock: write enable, read enable, address and data-background bit.
- Samples the comparator error flag, captures the first failing address and element, and reports pass/fail and completion.
- Sits between the BIST start/status interface and the memory/data generator/comparator.

Parameters:
- Adr_size, 4, address width; the sequence covers N = 2^Adr_size locations.
- STOP_ON_ERR, 0, 1 = abort the sequence on the first detected error; 0 = run to completion.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  launches a run when sampled high in IDLE or DONE.
- error  input  1  comparator mismatch; valid in the same cycle read_en is high.
- adr  output  Adr_size  memory address of the current operation.
- wr_en  output  1  write strobe for the current cycle.
- read_en  output  1  read/compare strobe for the current cycle.
- data_bit  output  1  background bit sent to the data generator (0 = all-zeros, 1 = all-ones).
- busy  output  1  high while operations are being issued.
- done  output  1  high in the DONE state; held until the next start or rst.
- status  output  1  sticky fault flag: 1 = at least one error seen in this run.
- fail_adr  output  Adr_size  address of the first error in this run.
- fail_elem  output  3  March element index (0-5) of the first error.

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE. All outputs are 0: adr, wr_en, read_en, data_bit, busy, done, status, fail_adr, fail_elem. rst has priority over everything.
- States: IDLE, RUN, DONE. Internal registers: elem (0-5), phase (0 = first op, 1 = second op), address counter.
- IDLE/DONE -> RUN: start=1 at edge k.
  - Clears status, fail_adr, fail_elem and done.
  - Sets elem=0, phase=0, adr=0.
  - busy=1 and the first operation appear in cycle k+1.
- start while in RUN is ignored.
- March C- elements (dir, ops):
  - E0: up, w0
  - E1: up, r0 then w1
  - E2: up, r1 then w0
  - E3: down, r0 then w1
  - E4: down, r1 then w0
  - E5: up, r0
- Per-cycle outputs:
  - A write cycle has wr_en=1, read_en=0.
  - A read cycle has read_en=1, wr_en=0.
  - data_bit is the value written or expected in that op.
  - wr_en and read_en are never high together.
  - Outside RUN both are 0.
- Two-op elements: phase 0 (read) and phase 1 (write) are issued at the same address in consecutive cycles. The address advances after phase 1.
- Address stepping:
  - Up elements start at 0 and end at N-1.
  - Down elements start at N-1 and end at 0.
  - After the last op of an element, the next cycle issues the first op of the next element at its start address. No idle cycle is inserted.
  - The address counter never wraps inside an element.
- Run length: total ops = 10N (160 for Adr_size=4), in cycles k+1 .. k+10N.
- RUN -> DONE: after the last E5 read.
  - done=1 and busy=0 from cycle k+10N+1.
  - adr returns to 0 and the strobes go low.
- Error capture:
  - error is sampled only in cycles where read_en=1; it is ignored otherwise.
  - On the first sampled error: status<=1, fail_adr<=adr, fail_elem<=elem.
  - Later errors do not change fail_adr or fail_elem.
- STOP_ON_ERR=1: an error sampled at edge j moves RUN -> DONE. done=1, busy=0 and the strobes go low in cycle j+1. No further ops are issued.
- status, fail_adr and fail_elem hold their values in DONE until the next start or rst.
- All outputs are registered; no combinational path from error to the strobes.

Test Plan:
- Fault-free run, Adr_size=4: pulse start, tie error=0.
  - Expect 160 consecutive op cycles, then done=1, status=0.
  - Check the first ops: (w0,adr0), (w0,adr1), ...
  - Check that E1 begins at adr0 with r0 then w1.
  - Check that E3 begins at adr15 with r0.
- Sequence check: log all 160 ops against a March C- model. Check the counts and that wr_en and read_en are never high together:
  - 16 w0 in E0.
  - E1-E4: alternating r/w, 32 ops each, addresses ascending 0..15 in E1/E2 and descending 15..0 in E3/E4.
  - 16 r0 ascending in E5.
- Single fault, STOP_ON_ERR=0: assert error on the E2 read at adr=5, and again on the E4 read at adr=9.
  - Expect status=1, fail_adr=5, fail_elem=2, unchanged by the second error.
  - Run completes in 160 ops.
- Abort, STOP_ON_ERR=1: assert error on the E3 read at adr=12.
  - Next cycle: done=1, busy=0, strobes low.
  - fail_elem=3, fail_adr=12.
- Control corner cases:
  - Pulse start mid-run: ignored, the run length is unchanged.
  - Assert rst during E1: all outputs 0 next cycle, state IDLE; a new start restarts from E0 adr0.
  - error high while read_en=0: status stays 0.
- Restart from DONE after a failed run: start clears status, fail_adr and fail_elem, and a clean run ends with status=0.
